// File: rtl/trdb_priority.sv
// ============================================================================
// Module   : trdb_priority
// Purpose  : E-Trace te_inst packet-priority arbiter with address sign-compression.
//            Optional macro TRDB_CONTEXT_PKT_EN enables SF_CONTEXT packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trdb_priority (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        lc_exception_i,
  input  logic        lc_updiscon_i,
  input  logic        lc_final_qualified_i,
  input  logic        tc_qualified_i,
  input  logic        tc_exception_i,
  input  logic        tc_retired_i,
  input  logic        tc_first_qualified_i,
  input  logic        tc_privchange_i,
  input  logic        tc_gt_max_resync_i,
  input  logic        tc_et_max_resync_i,
  input  logic        tc_branch_map_empty_i,
  input  logic        tc_branch_map_full_i,
  input  logic        tc_enc_enabled_i,
  input  logic        tc_enc_disabled_i,
  input  logic        tc_opmode_change_i,
  input  logic        nc_exception_i,
  input  logic        nc_privchange_i,
  input  logic        nc_branch_map_empty_i,
  input  logic        nc_qualified_i,
  input  logic        nc_retired_i,
  input  logic [31:0] addr_to_compress_i,
  output logic        valid_o,
  output logic [1:0]  packet_format_o,
  output logic [1:0]  packet_f_sync_subformat_o,
  output logic        thaddr_o,
  output logic        lc_tc_mux_o,
  output logic        resync_timer_rst_o,
  output logic [1:0]  qual_status_o,
  output logic [5:0]  keep_bits_o
);

  localparam logic [1:0] F_DIFF_DELTA = 2'd1;
  localparam logic [1:0] F_ADDR_ONLY  = 2'd2;
  localparam logic [1:0] F_SYNC       = 2'd3;

  localparam logic [1:0] SF_START     = 2'd0;
  localparam logic [1:0] SF_TRAP      = 2'd1;
  localparam logic [1:0] SF_SUPPORT   = 2'd3;

  localparam logic [1:0] QS_ENDED_REP = 2'd1;
  localparam logic [1:0] QS_ENDED_NTR = 2'd3;

  logic       started_q;
  logic       start_cond;
  logic       addr_reason;
  logic [1:0] addr_format;
  logic       set_started;
  logic       clr_started;
  logic       unused_nc;

  // Branch-map and retired lookahead on the nc side are not needed for arbitration.
  assign unused_nc = nc_branch_map_empty_i ^ nc_retired_i;

`ifdef TRDB_CONTEXT_PKT_EN
  assign start_cond = tc_first_qualified_i | tc_privchange_i | tc_enc_enabled_i |
                      (tc_gt_max_resync_i & tc_branch_map_empty_i) | ~started_q;
`else
  // Without context packets an opmode change forces a fresh start packet.
  assign start_cond = tc_first_qualified_i | tc_privchange_i | tc_enc_enabled_i |
                      (tc_gt_max_resync_i & tc_branch_map_empty_i) | ~started_q |
                      tc_opmode_change_i;
`endif

  assign addr_format = tc_branch_map_empty_i ? F_ADDR_ONLY : F_DIFF_DELTA;
  assign addr_reason = tc_qualified_i & tc_retired_i &
                       (nc_exception_i | nc_privchange_i | ~nc_qualified_i);

  always_comb begin
    valid_o                   = 1'b0;
    packet_format_o           = 2'd0;
    packet_f_sync_subformat_o = 2'd0;
    thaddr_o                  = 1'b0;
    lc_tc_mux_o               = 1'b0;
    resync_timer_rst_o        = 1'b0;
    qual_status_o             = 2'd0;
    if (valid_i) begin
      if (lc_exception_i) begin
        valid_o                   = 1'b1;
        packet_format_o           = F_SYNC;
        packet_f_sync_subformat_o = SF_TRAP;
        thaddr_o                  = ~tc_exception_i;
        lc_tc_mux_o               = 1'b1;
        resync_timer_rst_o        = 1'b1;
      end else if (tc_enc_disabled_i || lc_final_qualified_i) begin
        valid_o                   = 1'b1;
        packet_format_o           = F_SYNC;
        packet_f_sync_subformat_o = SF_SUPPORT;
        lc_tc_mux_o               = 1'b1;
        qual_status_o             = tc_enc_disabled_i ? QS_ENDED_NTR : QS_ENDED_REP;
      end else if (tc_qualified_i && start_cond) begin
        valid_o                   = 1'b1;
        packet_format_o           = F_SYNC;
        packet_f_sync_subformat_o = SF_START;
        resync_timer_rst_o        = 1'b1;
`ifdef TRDB_CONTEXT_PKT_EN
      end else if (tc_qualified_i && tc_opmode_change_i) begin
        valid_o                   = 1'b1;
        packet_format_o           = F_SYNC;
        packet_f_sync_subformat_o = 2'd2;
        resync_timer_rst_o        = 1'b1;
`endif
      end else if (started_q && lc_updiscon_i) begin
        valid_o         = 1'b1;
        packet_format_o = addr_format;
      end else if (started_q && tc_et_max_resync_i && !tc_branch_map_empty_i) begin
        valid_o            = 1'b1;
        packet_format_o    = addr_format;
        resync_timer_rst_o = 1'b1;
      end else if (started_q && addr_reason) begin
        valid_o         = 1'b1;
        packet_format_o = addr_format;
      end else if (started_q && tc_branch_map_full_i) begin
        valid_o         = 1'b1;
        packet_format_o = F_DIFF_DELTA;
      end
    end
  end

  assign set_started = valid_o && (packet_format_o == F_SYNC) &&
                       ((packet_f_sync_subformat_o == SF_START) ||
                        (packet_f_sync_subformat_o == SF_TRAP));
  assign clr_started = valid_o && (packet_format_o == F_SYNC) &&
                       (packet_f_sync_subformat_o == SF_SUPPORT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started_q <= 1'b0;
    end else if (set_started) begin
      started_q <= 1'b1;
    end else if (clr_started) begin
      started_q <= 1'b0;
    end
  end

  // Highest bit differing from the sign bit sets the kept length; none means 1.
  always_comb begin
    keep_bits_o = 6'd1;
    for (int i = 0; i < 31; i++) begin
      if (addr_to_compress_i[i] != addr_to_compress_i[31]) begin
        keep_bits_o = 6'(i + 2);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trdb_priority.sv
// ============================================================================
// Module   : tb_trdb_priority
// Purpose  : Directed self-checking bench for trdb_priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trdb_priority;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        lc_exception_i, lc_updiscon_i, lc_final_qualified_i;
  logic        tc_qualified_i, tc_exception_i, tc_retired_i, tc_first_qualified_i, tc_privchange_i;
  logic        tc_gt_max_resync_i, tc_et_max_resync_i;
  logic        tc_branch_map_empty_i, tc_branch_map_full_i;
  logic        tc_enc_enabled_i, tc_enc_disabled_i, tc_opmode_change_i;
  logic        nc_exception_i, nc_privchange_i, nc_branch_map_empty_i, nc_qualified_i, nc_retired_i;
  logic [31:0] addr_to_compress_i;
  logic        valid_o;
  logic [1:0]  packet_format_o;
  logic [1:0]  packet_f_sync_subformat_o;
  logic        thaddr_o;
  logic        lc_tc_mux_o;
  logic        resync_timer_rst_o;
  logic [1:0]  qual_status_o;
  logic [5:0]  keep_bits_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  trdb_priority dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .valid_i                   (valid_i),
    .lc_exception_i            (lc_exception_i),
    .lc_updiscon_i             (lc_updiscon_i),
    .lc_final_qualified_i      (lc_final_qualified_i),
    .tc_qualified_i            (tc_qualified_i),
    .tc_exception_i            (tc_exception_i),
    .tc_retired_i              (tc_retired_i),
    .tc_first_qualified_i      (tc_first_qualified_i),
    .tc_privchange_i           (tc_privchange_i),
    .tc_gt_max_resync_i        (tc_gt_max_resync_i),
    .tc_et_max_resync_i        (tc_et_max_resync_i),
    .tc_branch_map_empty_i     (tc_branch_map_empty_i),
    .tc_branch_map_full_i      (tc_branch_map_full_i),
    .tc_enc_enabled_i          (tc_enc_enabled_i),
    .tc_enc_disabled_i         (tc_enc_disabled_i),
    .tc_opmode_change_i        (tc_opmode_change_i),
    .nc_exception_i            (nc_exception_i),
    .nc_privchange_i           (nc_privchange_i),
    .nc_branch_map_empty_i     (nc_branch_map_empty_i),
    .nc_qualified_i            (nc_qualified_i),
    .nc_retired_i              (nc_retired_i),
    .addr_to_compress_i        (addr_to_compress_i),
    .valid_o                   (valid_o),
    .packet_format_o           (packet_format_o),
    .packet_f_sync_subformat_o (packet_f_sync_subformat_o),
    .thaddr_o                  (thaddr_o),
    .lc_tc_mux_o               (lc_tc_mux_o),
    .resync_timer_rst_o        (resync_timer_rst_o),
    .qual_status_o             (qual_status_o),
    .keep_bits_o               (keep_bits_o)
  );

  logic [9:0] outs;
  assign outs = {valid_o, packet_format_o, packet_f_sync_subformat_o, thaddr_o,
                 lc_tc_mux_o, resync_timer_rst_o, qual_status_o};

  // Packs expected fields in the same order as outs: v, fmt, sub, thaddr, mux, rrst, qual.
  function automatic logic [9:0] pk(input logic v, input logic [1:0] f, input logic [1:0] sf,
                                    input logic th, input logic mx, input logic rr,
                                    input logic [1:0] qs);
    return {v, f, sf, th, mx, rr, qs};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle vector: nc_qualified held high so the lookahead rule stays quiet.
  task automatic idle();
    valid_i = 1'b0;
    lc_exception_i = 1'b0; lc_updiscon_i = 1'b0; lc_final_qualified_i = 1'b0;
    tc_qualified_i = 1'b0; tc_exception_i = 1'b0; tc_retired_i = 1'b0;
    tc_first_qualified_i = 1'b0; tc_privchange_i = 1'b0;
    tc_gt_max_resync_i = 1'b0; tc_et_max_resync_i = 1'b0;
    tc_branch_map_empty_i = 1'b0; tc_branch_map_full_i = 1'b0;
    tc_enc_enabled_i = 1'b0; tc_enc_disabled_i = 1'b0; tc_opmode_change_i = 1'b0;
    nc_exception_i = 1'b0; nc_privchange_i = 1'b0; nc_branch_map_empty_i = 1'b0;
    nc_qualified_i = 1'b1; nc_retired_i = 1'b0;
    addr_to_compress_i = 32'h0;
  endtask

  task automatic step();
    @(negedge clk_i);
    idle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #1;
    check("reset_outputs", outs, pk(0, 0, 0, 0, 0, 0, 0));
    check("keep_zero", {4'b0, keep_bits_o}, 10'd1);
    repeat (2) @(posedge clk_i);
    step(); rst_i = 1'b0;

    step(); valid_i = 1; tc_qualified_i = 1; tc_first_qualified_i = 1; #1;
    check("first_start", outs, pk(1, 3, 0, 0, 0, 1, 0));

    step(); valid_i = 1; tc_qualified_i = 1; #1;
    check("started_quiet", outs, pk(0, 0, 0, 0, 0, 0, 0));

    step(); valid_i = 1; lc_exception_i = 1; #1;
    check("trap_thaddr1", outs, pk(1, 3, 1, 1, 1, 1, 0));

    step(); valid_i = 1; lc_exception_i = 1; tc_exception_i = 1; #1;
    check("trap_thaddr0", outs, pk(1, 3, 1, 0, 1, 1, 0));

    step(); valid_i = 1; lc_updiscon_i = 1; tc_branch_map_empty_i = 1; #1;
    check("updiscon_addr_only", outs, pk(1, 2, 0, 0, 0, 0, 0));

    step(); valid_i = 1; lc_updiscon_i = 1; #1;
    check("updiscon_diff_delta", outs, pk(1, 1, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_et_max_resync_i = 1; #1;
    check("et_max_resync", outs, pk(1, 1, 0, 0, 0, 1, 0));

    step(); valid_i = 1; tc_et_max_resync_i = 1; tc_branch_map_empty_i = 1; #1;
    check("et_max_empty_map", outs, pk(0, 0, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_qualified_i = 1; tc_retired_i = 1; nc_qualified_i = 0;
    tc_branch_map_empty_i = 1; #1;
    check("nc_unqualified", outs, pk(1, 2, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_qualified_i = 1; tc_retired_i = 1; nc_privchange_i = 1; #1;
    check("nc_privchange", outs, pk(1, 1, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_qualified_i = 1; tc_retired_i = 1; #1;
    check("nc_no_event", outs, pk(0, 0, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_branch_map_full_i = 1; #1;
    check("branch_full", outs, pk(1, 1, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_qualified_i = 1; tc_opmode_change_i = 1; #1;
`ifdef TRDB_CONTEXT_PKT_EN
    check("opmode_change", outs, pk(1, 3, 2, 0, 0, 1, 0));
`else
    check("opmode_change", outs, pk(1, 3, 0, 0, 0, 1, 0));
`endif

    step(); valid_i = 1; tc_qualified_i = 1; tc_gt_max_resync_i = 1; tc_branch_map_empty_i = 1; #1;
    check("gt_max_start", outs, pk(1, 3, 0, 0, 0, 1, 0));

    step(); valid_i = 1; tc_qualified_i = 1; tc_gt_max_resync_i = 1; #1;
    check("gt_max_nonempty", outs, pk(0, 0, 0, 0, 0, 0, 0));

    step(); valid_i = 1; lc_final_qualified_i = 1; #1;
    check("support_ended_rep", outs, pk(1, 3, 3, 0, 1, 0, 1));

    step(); valid_i = 1; tc_qualified_i = 1; #1;
    check("restart_after_rep", outs, pk(1, 3, 0, 0, 0, 1, 0));

    step(); valid_i = 1; tc_enc_disabled_i = 1; tc_qualified_i = 1; #1;
    check("support_ended_ntr", outs, pk(1, 3, 3, 0, 1, 0, 3));

    step(); valid_i = 1; tc_branch_map_full_i = 1; lc_updiscon_i = 1; #1;
    check("not_started_gated", outs, pk(0, 0, 0, 0, 0, 0, 0));

    step(); valid_i = 1; tc_qualified_i = 1; #1;
    check("restart_after_ntr", outs, pk(1, 3, 0, 0, 0, 1, 0));

    step(); valid_i = 1; lc_exception_i = 1; tc_enc_disabled_i = 1; #1;
    check("trap_beats_support", outs, pk(1, 3, 1, 1, 1, 1, 0));

    step(); lc_exception_i = 1; tc_branch_map_full_i = 1; tc_qualified_i = 1; #1;
    check("invalid_quiet", outs, pk(0, 0, 0, 0, 0, 0, 0));

    step(); rst_i = 1; #2; rst_i = 0;
    valid_i = 1; tc_qualified_i = 1; #1;
    check("start_after_reset", outs, pk(1, 3, 0, 0, 0, 1, 0));

    step(); addr_to_compress_i = 32'h0000_1000; #1;
    check("keep_1000", {4'b0, keep_bits_o}, 10'd14);
    addr_to_compress_i = 32'h8000_0000; #1;
    check("keep_80000000", {4'b0, keep_bits_o}, 10'd32);
    addr_to_compress_i = 32'hFFFF_F000; #1;
    check("keep_fffff000", {4'b0, keep_bits_o}, 10'd13);
    addr_to_compress_i = 32'hFFFF_FFFF; #1;
    check("keep_all_ones", {4'b0, keep_bits_o}, 10'd1);
    addr_to_compress_i = 32'h7FFF_FFFF; #1;
    check("keep_7fffffff", {4'b0, keep_bits_o}, 10'd32);
    addr_to_compress_i = 32'h0000_0001; #1;
    check("keep_one", {4'b0, keep_bits_o}, 10'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trdb_priority.md
Name: trdb_priority

Overview:
- Packet-priority arbiter of the RISC-V E-Trace encoder (trdb).
- Each valid cycle it takes last-cycle (lc), this-cycle (tc) and next-cycle (nc) instruction flags and decides whether a te_inst packet is emitted, and with which format and subformat.
- It also drives control to the packet emitter: thaddr, lc/tc payload mux, resync-timer reset and qualification status, plus the sign-compressed address length.
- It sits between the filter/lc-tc-nc pipeline and the packet emitter.

Parameters:
- None. Address width is fixed at 32.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  lc/tc/nc inputs are valid this cycle
- lc_exception_i  in  1  last-cycle instruction took an exception
- lc_updiscon_i  in  1  last-cycle instruction was an uninferable discontinuity
- lc_final_qualified_i  in  1  last-cycle instruction was the final qualified instruction
- tc_qualified_i, tc_exception_i, tc_retired_i, tc_first_qualified_i, tc_privchange_i  in  1 each  this-cycle instruction status
- tc_gt_max_resync_i, tc_et_max_resync_i  in  1 each  resync counter greater-than max / equal-to max
- tc_branch_map_empty_i, tc_branch_map_full_i  in  1 each  branch map status
- tc_enc_enabled_i, tc_enc_disabled_i, tc_opmode_change_i  in  1 each  encoder control events
- nc_exception_i, nc_privchange_i, nc_branch_map_empty_i, nc_qualified_i, nc_retired_i  in  1 each  next-cycle status
- addr_to_compress_i  in  32  address to be sign-compressed
- valid_o  out  1  packet request
- packet_format_o  out  2  0 F_OPT_EXT, 1 F_DIFF_DELTA, 2 F_ADDR_ONLY, 3 F_SYNC
- packet_f_sync_subformat_o  out  2  0 SF_START, 1 SF_TRAP, 2 SF_CONTEXT, 3 SF_SUPPORT
- thaddr_o  out  1  trap packet: address is the handler address
- lc_tc_mux_o  out  1  1 selects last-cycle payload, 0 selects this-cycle payload
- resync_timer_rst_o  out  1  clear the resync counter
- qual_status_o  out  2  0 no_change, 1 ended_rep, 2 trace_lost, 3 ended_ntr
- keep_bits_o  out  6  significant bits of the sign-compressed address (1..32)

Behaviour:
- All outputs are combinational from the current inputs plus one state bit. Zero latency: outputs settle in the same cycle the inputs are applied.
- State bit started_q:
  - Async reset to 0.
  - Set on a clock edge when a start packet or a trap packet is emitted.
  - Cleared on a clock edge when a support packet is emitted.
- Default values, held whenever valid_i=0 and for any field not overridden below:
  - valid_o=0, format=0, subformat=0, thaddr=0, lc_tc_mux=0, resync_rst=0, qual_status=0.
- "addr packet": valid_o=1; format=2 if tc_branch_map_empty_i, else 1.
- When valid_i=1, the first matching rule wins:
  - R1 lc_exception_i -> F_SYNC/SF_TRAP; thaddr=!tc_exception_i; lc_tc_mux=1; resync_rst=1.
  - R2 tc_enc_disabled_i or lc_final_qualified_i -> F_SYNC/SF_SUPPORT; lc_tc_mux=1.
    - qual_status=3 if tc_enc_disabled_i.
    - Otherwise qual_status=1.
  - R3 tc_qualified_i and any of the following -> F_SYNC/SF_START; resync_rst=1:
    - tc_first_qualified_i
    - tc_privchange_i
    - tc_enc_enabled_i
    - tc_gt_max_resync_i & tc_branch_map_empty_i
    - !started_q
  - R4 tc_qualified_i & tc_opmode_change_i -> F_SYNC/SF_CONTEXT; resync_rst=1. This rule is governed by the optional feature.
  - R5 lc_updiscon_i -> addr packet.
  - R6 tc_et_max_resync_i & !tc_branch_map_empty_i -> addr packet; resync_rst=1.
  - R7 tc_qualified_i & tc_retired_i & (nc_exception_i | nc_privchange_i | !nc_qualified_i) -> addr packet.
  - R8 tc_branch_map_full_i -> valid_o=1, format=1 (branch count only, no address).
  - Otherwise valid_o=0.
- R5–R8 additionally require started_q=1.
- keep_bits_o is computed regardless of valid_i:
  - L = number of leading bits of addr_to_compress_i equal to bit 31 (1..32).
  - keep_bits_o = 33 - L.
  - All-zeros or all-ones gives 1.
- Reset mid-operation clears started_q immediately. The next valid qualified cycle then yields a start packet.

Optional Feature:
- Macro TRDB_CONTEXT_PKT_EN.
- Defined: R4 is active and emits SF_CONTEXT.
- Undefined: R4 is removed and tc_opmode_change_i is added to the R3 start conditions, so it emits SF_START with resync_rst=1.

Test Plan:
- Reset, then valid_i=1, tc_qualified_i=1, tc_first_qualified_i=1 -> valid_o=1, format=3, subformat=0, resync_rst=1. The next cycle's started_q=1.
- lc_exception_i=1, tc_exception_i=0 -> format=3, subformat=1, thaddr=1, lc_tc_mux=1. Same with tc_exception_i=1 -> thaddr=0.
- After start, lc_updiscon_i=1 with tc_branch_map_empty_i=1 -> format=2. With tc_branch_map_empty_i=0 -> format=1.
- tc_enc_disabled_i=1 -> format=3, subformat=3, qual_status=3. Next cycle, a qualified instruction gives SF_START.
- After start, tc_branch_map_full_i=1 with no other events -> valid_o=1, format=1. valid_i=0 -> all outputs 0.
- addr_to_compress_i 0x00000000 -> keep=1; 0x00001000 -> 14; 0x80000000 -> 32; 0xFFFFF000 -> 13.
